// File: rtl/imem_loader_if.sv
// Loader bus: session control, word stream from the source, byte-write
// port toward instruction memory and fetch-unit hold/status outputs.
interface imem_loader_if #(
   parameter int word_size = 32
);
   logic                 load_en;
   logic [word_size-1:0] base_addr;
   logic                 in_valid;
   logic [word_size-1:0] in_data;
   logic                 in_last;
   logic                 in_ready;
   logic                 mem_we;
   logic [word_size-1:0] mem_addr;
   logic [7:0]           mem_wdata;
   logic                 start;
   logic [word_size-1:0] start_address;
   logic                 busy;
   logic                 done;
   logic                 error;
   logic [15:0]          word_count;

   // Source / supervisor side: drives requests and words, observes everything else.
   modport master (
      output load_en, base_addr, in_valid, in_data, in_last,
      input  in_ready, mem_we, mem_addr, mem_wdata, start, start_address,
             busy, done, error, word_count
   );

   // Loader side.
   modport slave (
      input  load_en, base_addr, in_valid, in_data, in_last,
      output in_ready, mem_we, mem_addr, mem_wdata, start, start_address,
             busy, done, error, word_count
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a stream of words and writes each one
// big-endian, one byte per cycle, starting at a session base address.
// Holds the fetch unit (start=1) until a session has completed.
module imem_loader #(
   parameter int word_size = 32,
   parameter int MEM_BYTES = 1024
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

   state_t               state_q, state_d;
   logic [word_size-1:0] ptr_q, ptr_d;
   logic [word_size-1:0] word_q, word_d;
   logic [word_size-1:0] start_addr_q, start_addr_d;
   logic [1:0]           idx_q, idx_d;
   logic                 last_q, last_d;
   logic                 drop_q, drop_d;
   logic                 start_q, start_d;
   logic                 error_q, error_d;
   logic [15:0]          wcnt_q, wcnt_d;

   logic [word_size-1:0] ptr_plus4;
   logic [7:0]           byte_sel;

   // Pointer advance wraps naturally at word_size bits.
   assign ptr_plus4 = ptr_q + word_size'(4);

   assign bus.start         = start_q;
   assign bus.start_address = start_addr_q;
   assign bus.busy          = (state_q != IDLE);
   assign bus.error         = error_q;
   assign bus.word_count    = wcnt_q;

   // State and datapath registers; reset parks the fetch unit (start=1).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         word_q       <= '0;
         start_addr_q <= '0;
         idx_q        <= '0;
         last_q       <= 1'b0;
         drop_q       <= 1'b0;
         start_q      <= 1'b1;
         error_q      <= 1'b0;
         wcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         word_q       <= word_d;
         start_addr_q <= start_addr_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         drop_q       <= drop_d;
         start_q      <= start_d;
         error_q      <= error_d;
         wcnt_q       <= wcnt_d;
      end
   end

   // Big-endian byte lane: index 0 is the most significant byte.
   always_comb begin
      byte_sel = '0;
      unique case (idx_q)
         2'd0: byte_sel = word_q[word_size-1  -: 8];
         2'd1: byte_sel = word_q[word_size-9  -: 8];
         2'd2: byte_sel = word_q[word_size-17 -: 8];
         2'd3: byte_sel = word_q[word_size-25 -: 8];
         default: byte_sel = '0;
      endcase
   end

   // Next-state and output decode.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      word_d       = word_q;
      start_addr_d = start_addr_q;
      idx_d        = idx_q;
      last_d       = last_q;
      drop_d       = drop_q;
      start_d      = start_q;
      error_d      = error_q;
      wcnt_d       = wcnt_q;
      bus.in_ready  = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.load_en) begin
               ptr_d        = bus.base_addr;
               start_addr_d = bus.base_addr;
               wcnt_d       = '0;
               error_d      = 1'b0;
               start_d      = 1'b1;
               state_d      = ACCEPT;
            end
         end
         ACCEPT: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               word_d = bus.in_data;
               last_d = bus.in_last;
               // A word that would run past the end of memory is counted but not written.
               drop_d = (ptr_plus4 > word_size'(MEM_BYTES));
               if (ptr_plus4 > word_size'(MEM_BYTES)) begin
                  error_d = 1'b1;
               end
               if (wcnt_q != 16'hFFFF) begin
                  wcnt_d = wcnt_q + 16'd1;
               end
               idx_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!drop_q) begin
               bus.mem_we    = 1'b1;
               bus.mem_addr  = ptr_q + word_size'(idx_q);
               bus.mem_wdata = byte_sel;
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               ptr_d   = ptr_plus4;
               state_d = last_q ? FINISH : ACCEPT;
            end
         end
         FINISH: begin
            bus.done = 1'b1;
            start_d  = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
